ps2_interface: RTL and testbench

Receive-only PS/2 keyboard front end for the board top level. It samples the keyboard's open-collector clock and data lines and deframes 11-bit device-to-host frames. It reports every valid byte with a one-cycle strobe and holds the most recent make code for the LCD and seven-segment consumers. It never drives the PS/2 lines.

---
 rtl/ps2_interface.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_interface.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_interface.sv
// ps2_interface: receive-only PS/2 keyboard front end.
// Synchronizes and debounces the PS/2 clock, deframes 11-bit device-to-host
// frames, strobes every valid byte and tracks the most recent make code.
// The PS/2 lines are never driven by this block.
module ps2_interface #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clock,
    input  logic       resetn,
    inout  wire        ps2_clock,
    inout  wire        ps2_data,
    output logic [7:0] ps2_key_data,
    output logic       ps2_key_pressed,
    output logic [7:0] ps2_out
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity over data and parity bit: a correct frame XORs to 1.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Open-collector lines: the host side only listens.
    assign ps2_clock = 1'bz;
    assign ps2_data  = 1'bz;

    logic [1:0]        r_clk_sync;
    logic [1:0]        r_dat_sync;
    logic              r_filt_clk;
    logic [FILT_W-1:0] r_filt_cnt;
    state_t            r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_par;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_break_pending;
    logic [7:0]        r_key_data;
    logic              r_key_pressed;
    logic [7:0]        r_out;

    logic              w_clk_s;
    logic              w_data;
    logic              w_fall;
    state_t            w_state_next;
    logic [2:0]        w_bit_cnt_next;
    logic [7:0]        w_shift_next;
    logic              w_par_next;
    logic [TO_W-1:0]   w_to_cnt_next;
    logic              w_frame_ok;

    assign w_clk_s = r_clk_sync[1];
    assign w_data  = r_dat_sync[1];

    // Two-flop synchronizers; they idle high like the released bus lines.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clock};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    // Clock filter: follow the synchronized level only after FILTER_LEN
    // consecutive samples that disagree with the current filtered level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (w_clk_s == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FILT_LAST) begin
            r_filt_clk <= w_clk_s;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FILT_W'(1);
        end
    end

    // A fall event is the cycle in which the filtered clock is about to drop.
    assign w_fall = r_filt_clk & ~w_clk_s & (r_filt_cnt == FILT_LAST);

    // Receiver state and frame datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_par     <= w_par_next;
            r_to_cnt  <= w_to_cnt_next;
        end
    end

    // Next-state logic: deframing on fall events, inter-edge timeout inside a frame.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_par_next     = r_par;
        w_to_cnt_next  = '0;
        w_frame_ok     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !w_data) begin
                    w_state_next   = ST_DATA;
                    w_bit_cnt_next = 3'd0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_fall) begin
                    w_shift_next = {w_data, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next   = ST_PARITY;
                        w_bit_cnt_next = 3'd0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_W'(1);
                end
            end
            ST_PARITY: begin
                if (w_fall) begin
                    w_par_next   = w_data;
                    w_state_next = ST_STOP;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_W'(1);
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_frame_ok   = w_data & odd_parity_ok(r_shift, r_par);
                    w_state_next = ST_IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output registers: byte strobe plus make-code tracking (F0 marks a break,
    // E0 is a transparent prefix, the byte after F0 is swallowed).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_key_data      <= 8'h00;
            r_key_pressed   <= 1'b0;
            r_out           <= 8'h00;
            r_break_pending <= 1'b0;
        end else begin
            r_key_pressed <= w_frame_ok;
            if (w_frame_ok) begin
                r_key_data <= r_shift;
                if (r_shift == BREAK_CODE) begin
                    r_break_pending <= 1'b1;
                end else if (r_shift == EXT_CODE) begin
                    r_break_pending <= r_break_pending;
                end else if (r_break_pending) begin
                    r_break_pending <= 1'b0;
                end else begin
                    r_out <= r_shift;
                end
            end
        end
    end

    assign ps2_key_data    = r_key_data;
    assign ps2_key_pressed = r_key_pressed;
    assign ps2_out         = r_out;

endmodule

// File: tb/tb_ps2_interface.sv
// Scoreboard bench for ps2_interface: directed frames push expected bytes at
// the stop-bit falling edge; a monitor pops and checks on every strobe.
module tb_ps2_interface;

    localparam int FILT = 8;
    localparam int TO   = 400;
    localparam int HALF = 40;

    typedef struct {
        logic [7:0] key;
        logic [7:0] out;
        int         fall_cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       r_clk_drv;
    logic       r_dat_drv;
    wire        w_ps2_clock;
    wire        w_ps2_data;
    logic [7:0] key_data;
    logic       pressed;
    logic [7:0] out;

    assign w_ps2_clock = r_clk_drv;
    assign w_ps2_data  = r_dat_drv;

    ps2_interface #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ps2_clock      (w_ps2_clock),
        .ps2_data       (w_ps2_data),
        .ps2_key_data   (key_data),
        .ps2_key_pressed(pressed),
        .ps2_out        (out)
    );

    always #10 clock = ~clock;

    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t q[$];
    exp_t mon_e;
    logic prev_pressed = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected frame.
    always @(negedge clock) begin
        prev_pressed <= pressed;
        if (pressed === 1'b1) begin
            check8("strobe_one_cycle", {7'd0, prev_pressed}, 8'h00);
            if (q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_strobe: got key %h out %h expected no strobe", key_data, out);
            end else begin
                mon_e = q.pop_front();
                check8("key_data", key_data, mon_e.key);
                check8("ps2_out", out, mon_e.out);
                tests_run++;
                if ((cyc - mon_e.fall_cyc) < FILT + 2 || (cyc - mon_e.fall_cyc) > FILT + 4) begin
                    tests_failed++;
                    $display("FAIL latency: got %0d cycles expected %0d..%0d", cyc - mon_e.fall_cyc, FILT + 2, FILT + 4);
                end
            end
        end
    end

    // Drive one 11-bit frame; optionally corrupt parity/stop or glitch the clock.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input logic expect_ok, input logic [7:0] exp_out, input int glitch_bit);
        logic [10:0] bits;
        logic        p;
        p    = ~(^d) ^ bad_par;
        bits = {stop, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(posedge clock); #1 r_dat_drv = bits[i];
            repeat (HALF) @(posedge clock);
            #1 r_clk_drv = 1'b0;
            if (i == 10 && expect_ok) q.push_back('{d, exp_out, cyc});
            repeat (HALF) @(posedge clock);
            #1 r_clk_drv = 1'b1;
            if (i == glitch_bit) begin
                repeat (HALF / 4) @(posedge clock);
                #1 r_clk_drv = 1'b0;
                repeat (3) @(posedge clock);
                #1 r_clk_drv = 1'b1;
            end
        end
        @(posedge clock); #1 r_dat_drv = 1'b1;
        repeat (2 * HALF) @(posedge clock);
    endtask

    // Drive a start bit and the first n data bits, then leave the bus idle.
    task automatic send_partial(input logic [7:0] d, input int n);
        logic [8:0] bits;
        bits = {d, 1'b0};
        for (int i = 0; i <= n; i++) begin
            @(posedge clock); #1 r_dat_drv = bits[i];
            repeat (HALF) @(posedge clock);
            #1 r_clk_drv = 1'b0;
            repeat (HALF) @(posedge clock);
            #1 r_clk_drv = 1'b1;
        end
        @(posedge clock); #1 r_dat_drv = 1'b1;
    endtask

    initial begin
        resetn    = 1'b1;
        r_clk_drv = 1'b1;
        r_dat_drv = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check8("reset_key_data", key_data, 8'h00);
        check8("reset_ps2_out", out, 8'h00);
        check8("reset_pressed", {7'd0, pressed}, 8'h00);
        repeat (5) @(posedge clock);
        #1 resetn = 1'b1;
        repeat (20) @(posedge clock);

        // Short low glitch while idle must not start a frame.
        #1 r_clk_drv = 1'b0;
        repeat (3) @(posedge clock);
        #1 r_clk_drv = 1'b1;
        repeat (20) @(posedge clock);

        // Basic make, then make/break/make with 1-bit gaps, then extended prefix.
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, -1);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, -1);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b1, 8'h1C, -1);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, -1);
        send_frame(8'h32, 1'b0, 1'b1, 1'b1, 8'h32, -1);
        send_frame(8'hE0, 1'b0, 1'b1, 1'b1, 8'h32, -1);

        // Parity error and stop error are dropped silently.
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, -1);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, -1);
        repeat (20) @(posedge clock);
        check8("hold_key_after_errors", key_data, 8'hE0);
        check8("hold_out_after_errors", out, 8'h32);

        // Abandoned partial frame, then timeout, then a good frame.
        send_partial(8'hA5, 4);
        repeat (TO + 100) @(posedge clock);
        send_frame(8'h45, 1'b0, 1'b1, 1'b1, 8'h45, -1);

        // Mid-frame clock glitch.
        send_frame(8'h29, 1'b0, 1'b1, 1'b1, 8'h29, 3);

        // Asynchronous reset in the middle of a frame.
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, -1);
        check8("pre_reset_out", out, 8'h1C);
        send_partial(8'h5A, 4);
        @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check8("async_reset_key_data", key_data, 8'h00);
        check8("async_reset_ps2_out", out, 8'h00);
        check8("async_reset_pressed", {7'd0, pressed}, 8'h00);
        repeat (10) @(posedge clock);
        #1 resetn = 1'b1;
        repeat (20) @(posedge clock);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, -1);

        // Drain: every expected frame must have been strobed.
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clock);
        tests_run++;
        if (q.size() != 0) begin
            tests_failed++;
            $display("FAIL missing_strobe: got %0d pending frames expected 0", q.size());
        end
        check8("final_key_data", key_data, 8'h5A);
        check8("final_ps2_out", out, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
